ht_convert_seq: RTL and testbench
=================================

# ht_convert_seq

Sequencer for the hidden-state conversion stage of the LSTM cell. After the gate/state pipeline has filled the 32-bit inner-product accumulator bank, a `start` pulse makes this block walk every hidden unit. For each unit it fetches the accumulator word and its bias byte, presents them to the combinational Ht quantizer, and writes the saturated 8-bit Ht into the Ht buffer under ready/valid backpressure. It also counts saturated results for debug.

## Interface
Parameters:
- `NUM_HIDDEN`, 8: number of hidden units converted per run (1..2^ADDR_W).
- `ADDR_W`, 3: width of every address port.
- `ACC_W`, 32: accumulator word width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle run request; ignored unless in IDLE.
- `abort`, in, 1: synchronous cancel; returns to IDLE with no `done`.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse after the last write is accepted.
- `acc_rd_en`, out, 1: accumulator read strobe.
- `acc_rd_addr`, out, ADDR_W: accumulator read address.
- `acc_rd_data`, in, ACC_W: accumulator read data, valid 1 cycle after `acc_rd_en`.
- `bias_rd_addr`, out, ADDR_W: bias buffer address, strobed by `acc_rd_en`.
- `bias_rd_data`, in, 8: bias byte, valid 1 cycle after `acc_rd_en`.
- `conv_state`, out, 3: drives the quantizer's `lstm_state`. It equals CTXT_CONVERT (3'd4) only in CONV and is IDLE (3'd0) otherwise.
- `conv_inpdt`, out, ACC_W: registered accumulator operand to the quantizer.
- `conv_bias`, out, 8: registered bias operand to the quantizer.
- `conv_ht`, in, 8: saturated Ht from the quantizer (combinational).
- `ht_wr_valid`, out, 1: Ht write request.
- `ht_wr_ready`, in, 1: Ht buffer accepts a write when high together with valid.
- `ht_wr_addr`, out, ADDR_W: Ht write address.
- `ht_wr_data`, out, 8: Ht write data.
- `sat_count`, out, ADDR_W+1: number of results equal to 0 or 255 in the current or last run.

## Operation
- States: IDLE, FETCH, LOAD, CONV, WRITE, DONE.
- IDLE: on `start`, clear `idx` and `sat_count`, then go to FETCH.
- FETCH: assert `acc_rd_en`, with `acc_rd_addr = bias_rd_addr = idx`. Go to LOAD.
- LOAD: register `acc_rd_data` into `conv_inpdt` and `bias_rd_data` into `conv_bias`. Go to CONV.
- CONV:
  - `conv_state` = 3'd4.
  - Capture `conv_ht` into the `ht_wr_data` register.
  - If the result is 8'd0 or 8'd255, increment `sat_count`; it saturates at its all-ones value.
  - Go to WRITE.
- WRITE:
  - `ht_wr_valid` = 1, `ht_wr_addr = idx`.
  - Data, address and valid hold stable until `ht_wr_ready`.
  - On acceptance: if `idx == NUM_HIDDEN-1` go to DONE, else increment `idx` and go to FETCH.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- `abort`:
  - Has priority over every transition; in any non-IDLE state the next state is IDLE.
  - An un-accepted write is dropped.
  - `sat_count` holds its value.
- `start` while busy is ignored. `start` and `abort` together in IDLE: `abort` wins and the block stays IDLE.
- `conv_inpdt` and `conv_bias` are zeroed whenever the block leaves CONV, so the quantizer sees zero operands outside CONV.

## Timing
- Reset values:
  - All outputs are 0; `conv_state` = 3'd0.
  - State = IDLE; `idx` = 0; `sat_count` = 0.
- Per-unit latency with `ht_wr_ready` tied high is 4 cycles (FETCH, LOAD, CONV, WRITE).
- A full run takes 4*NUM_HIDDEN + 1 cycles from the `start` edge to the `done` pulse.
- Each cycle of `ht_wr_ready` low extends WRITE by one cycle.
- Memory read latency is exactly 1 cycle. There is no read backpressure.
- `resetn` asserted mid-run forces the reset values immediately (asynchronous), with no `done` and no further writes.
- NUM_HIDDEN = 1: a single pass ending in DONE. `idx` never wraps.

## Structure
- Shared package `lstm_ctrl_pkg`:
  - lstm_state encodings: IDLE=0, SYSTEM=1, BRANCH=2, INITIALIZE_W_B=3, CTXT_CONVERT=4, ERROR=7.
  - This block's state enum.
  - Saturation limit constants 8'd0 and 8'd255.
- No sub-module inside. The quantizer is instantiated beside this block at the top level, not inside it.

## Test plan
The bench instantiates the Ht quantizer with default parameters, so Ht = inpdt/128 + bias*128/256 + 128.
1. NUM_HIDDEN=8 with `ht_wr_ready` tied high. `acc[i] = 1280*i`, `bias[i] = 20` -> writes at addr i with data 138+10*i for i=0..7 (i=7 -> 208). `done` arrives exactly 33 cycles after `start`; `sat_count` = 0.
2. `acc[0] = 32000` (result 378 -> 255) and `acc[1] = -20480` (result -32 -> 0), others 0, `bias` = 0 -> data 255, 0, then 128 six times; `sat_count` = 2.
3. Backpressure: `ht_wr_ready` low for 3 cycles on unit 2 -> addr 2 and its data held stable; total run length 36 cycles; write order unchanged.
4. `abort` asserted in CONV of unit 4 -> `busy` low next cycle, no `done`, no write to addr 4. A new `start` then runs cleanly from addr 0.
5. `resetn` pulsed low during WRITE -> all outputs 0 immediately. `start` asserted during an active run -> ignored, run completes normally.

Source files
------------

// File: rtl/lstm_ctrl_pkg.sv
// Shared LSTM control definitions: quantizer stage encodings, the Ht
// conversion sequencer states and the Ht saturation limits.
package lstm_ctrl_pkg;

  typedef enum logic [2:0] {
    LS_IDLE         = 3'd0,
    LS_SYSTEM       = 3'd1,
    LS_BRANCH       = 3'd2,
    LS_INIT_W_B     = 3'd3,
    LS_CTXT_CONVERT = 3'd4,
    LS_ERROR        = 3'd7
  } lstm_state_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_CONV  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } cvt_state_e;

  localparam logic [7:0] HT_SAT_LO = 8'd0;
  localparam logic [7:0] HT_SAT_HI = 8'd255;

  function automatic logic ht_is_sat(input logic [7:0] ht);
    return (ht == HT_SAT_LO) || (ht == HT_SAT_HI);
  endfunction

endpackage

// File: rtl/ht_convert_seq_if.sv
// Memory-side bus of the Ht conversion sequencer: accumulator/bias reads
// and the ready/valid Ht buffer write port.
interface ht_convert_seq_if #(
  parameter int ADDR_W = 3,
  parameter int ACC_W  = 32
);
  logic              acc_rd_en;
  logic [ADDR_W-1:0] acc_rd_addr;
  logic [ACC_W-1:0]  acc_rd_data;
  logic [ADDR_W-1:0] bias_rd_addr;
  logic [7:0]        bias_rd_data;
  logic              ht_wr_valid;
  logic              ht_wr_ready;
  logic [ADDR_W-1:0] ht_wr_addr;
  logic [7:0]        ht_wr_data;

  modport master (
    output acc_rd_en, acc_rd_addr, bias_rd_addr, ht_wr_valid, ht_wr_addr, ht_wr_data,
    input  acc_rd_data, bias_rd_data, ht_wr_ready
  );

  modport slave (
    input  acc_rd_en, acc_rd_addr, bias_rd_addr, ht_wr_valid, ht_wr_addr, ht_wr_data,
    output acc_rd_data, bias_rd_data, ht_wr_ready
  );
endinterface

// File: rtl/ht_convert_seq.sv
// Walks every hidden unit: fetch accumulator + bias, present them to the
// external Ht quantizer, and write the saturated Ht under backpressure.
module ht_convert_seq
  import lstm_ctrl_pkg::*;
#(
  parameter int NUM_HIDDEN = 8,
  parameter int ADDR_W     = 3,
  parameter int ACC_W      = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [2:0]        conv_state,
  output logic [ACC_W-1:0]  conv_inpdt,
  output logic [7:0]        conv_bias,
  input  logic [7:0]        conv_ht,
  output logic [ADDR_W:0]   sat_count,
  ht_convert_seq_if.master  mem
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_HIDDEN - 1);

  cvt_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   sat_q, sat_d;
  logic [ACC_W-1:0]  inpdt_q, inpdt_d;
  logic [7:0]        bias_q, bias_d;
  logic [7:0]        wdata_q, wdata_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      sat_q   <= '0;
      inpdt_q <= '0;
      bias_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sat_q   <= sat_d;
      inpdt_q <= inpdt_d;
      bias_q  <= bias_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sat_d   = sat_q;
    inpdt_d = inpdt_q;
    bias_d  = bias_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FETCH;
        idx_d   = '0;
        sat_d   = '0;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        inpdt_d = mem.acc_rd_data;
        bias_d  = mem.bias_rd_data;
        state_d = S_CONV;
      end
      S_CONV: begin
        wdata_d = conv_ht;
        if (ht_is_sat(conv_ht) && (sat_q != '1)) sat_d = sat_q + (ADDR_W+1)'(1);
        // operands only live for the single CONV cycle
        inpdt_d = '0;
        bias_d  = '0;
        state_d = S_WRITE;
      end
      S_WRITE: if (mem.ht_wr_ready) begin
        if (idx_q == LAST_IDX) state_d = S_DONE;
        else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // abort overrides everything, including a start in IDLE
    if (abort) begin
      state_d = S_IDLE;
      idx_d   = idx_q;
      sat_d   = sat_q;
      inpdt_d = '0;
      bias_d  = '0;
      wdata_d = wdata_q;
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign conv_state       = (state_q == S_CONV) ? LS_CTXT_CONVERT : LS_IDLE;
  assign conv_inpdt       = inpdt_q;
  assign conv_bias        = bias_q;
  assign sat_count        = sat_q;
  assign mem.acc_rd_en    = (state_q == S_FETCH);
  assign mem.acc_rd_addr  = idx_q;
  assign mem.bias_rd_addr = idx_q;
  assign mem.ht_wr_valid  = (state_q == S_WRITE);
  assign mem.ht_wr_addr   = idx_q;
  assign mem.ht_wr_data   = wdata_q;

endmodule

// File: tb/tb_ht_convert_seq.sv
// Directed bench for ht_convert_seq with a behavioural quantizer, 1-cycle
// read memories and a write log.
module tb_ht_convert_seq;
  import lstm_ctrl_pkg::*;

  logic        clk = 0, resetn = 0, start = 0, abort = 0;
  logic        busy, done;
  logic [2:0]  conv_state;
  logic [31:0] conv_inpdt;
  logic [7:0]  conv_bias, conv_ht;
  logic [3:0]  sat_count;

  ht_convert_seq_if #(.ADDR_W(3), .ACC_W(32)) mem ();

  ht_convert_seq #(.NUM_HIDDEN(8), .ADDR_W(3), .ACC_W(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .busy(busy), .done(done), .conv_state(conv_state),
    .conv_inpdt(conv_inpdt), .conv_bias(conv_bias), .conv_ht(conv_ht),
    .sat_count(sat_count), .mem(mem)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [31:0] acc_mem [8];
  logic [7:0]  bias_mem [8];
  int wa[$], wd[$];
  int exp_d [8];
  bit bp_en = 0;
  int stall_left;
  logic bp_hold;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] quant(input logic [31:0] a, input logic [7:0] b);
    int sa, sb, v;
    sa = $signed(a);
    sb = $signed(b);
    v  = sa / 128 + (sb * 128) / 256 + 128;
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  assign conv_ht = (conv_state == 3'd4) ? quant(conv_inpdt, conv_bias) : 8'd0;

  always @(posedge clk) if (mem.acc_rd_en) begin
    mem.acc_rd_data  <= acc_mem[mem.acc_rd_addr];
    mem.bias_rd_data <= bias_mem[mem.bias_rd_addr];
  end

  assign bp_hold = bp_en && mem.ht_wr_valid && (mem.ht_wr_addr == 3'd2) && (stall_left != 0);
  assign mem.ht_wr_ready = !bp_hold;
  always @(posedge clk) begin
    if (!bp_en) stall_left <= 3;
    else if (bp_hold) stall_left <= stall_left - 1;
  end

  always @(negedge clk) begin
    if (mem.ht_wr_valid && mem.ht_wr_ready) begin
      wa.push_back(int'(mem.ht_wr_addr));
      wd.push_back(int'(mem.ht_wr_data));
    end
    if (mem.ht_wr_valid && !mem.ht_wr_ready) begin
      chk("bp_addr", 32'(mem.ht_wr_addr), 32'd2);
      chk("bp_data", 32'(mem.ht_wr_data), 32'd158);
    end
  end

  task automatic run(input int abort_unit, input int restart_at, output int cyc);
    int convs = 0;
    bit fin = 0;
    wa.delete(); wd.delete();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0; cyc = 1;
    while (!fin) begin
      @(negedge clk);
      if (done) fin = 1;
      else if (cyc > 200) begin
        chk("timeout", 32'(cyc), 32'd0);
        fin = 1;
      end else begin
        if (conv_state == 3'd4) begin
          if (convs == abort_unit) begin
            abort = 1;
            @(posedge clk); #1 abort = 0;
            @(negedge clk);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_inpdt", conv_inpdt, 32'd0);
            fin = 1;
          end
          convs++;
        end
        if (!fin) begin
          @(posedge clk); #1 cyc++;
          start = (cyc == restart_at);
        end
      end
    end
    start = 0;
  endtask

  task automatic chk_writes(input int n);
    chk("wr_count", 32'(wa.size()), 32'(n));
    for (int i = 0; i < n && i < wa.size(); i++) begin
      chk($sformatf("wr_addr%0d", i), 32'(wa[i]), 32'(i));
      chk($sformatf("wr_data%0d", i), 32'(wd[i]), 32'(exp_d[i]));
    end
  endtask

  task automatic after_done();
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc, nw;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(mem.ht_wr_valid), 32'd0);
    chk("rst_rden", 32'(mem.acc_rd_en), 32'd0);
    chk("rst_state", 32'(conv_state), 32'd0);
    chk("rst_sat", 32'(sat_count), 32'd0);
    @(negedge clk); resetn = 1;

    // 1: ramp, no saturation
    for (int i = 0; i < 8; i++) begin
      acc_mem[i] = 32'(1280 * i); bias_mem[i] = 8'd20; exp_d[i] = 138 + 10 * i;
    end
    run(-1, -1, cyc);
    chk("t1_cycles", 32'(cyc), 32'd33);
    chk_writes(8);
    chk("t1_sat", 32'(sat_count), 32'd0);
    after_done();

    // 2: both saturation limits
    for (int i = 0; i < 8; i++) begin
      acc_mem[i] = 32'd0; bias_mem[i] = 8'd0; exp_d[i] = 128;
    end
    acc_mem[0] = 32'd32000;  exp_d[0] = 255;
    acc_mem[1] = -32'sd20480; exp_d[1] = 0;
    run(-1, -1, cyc);
    chk("t2_cycles", 32'(cyc), 32'd33);
    chk_writes(8);
    chk("t2_sat", 32'(sat_count), 32'd2);
    after_done();

    // 3: backpressure on unit 2
    for (int i = 0; i < 8; i++) begin
      acc_mem[i] = 32'(1280 * i); bias_mem[i] = 8'd20; exp_d[i] = 138 + 10 * i;
    end
    bp_en = 1;
    run(-1, -1, cyc);
    chk("t3_cycles", 32'(cyc), 32'd36);
    chk_writes(8);
    bp_en = 0;
    after_done();

    // 4: abort in CONV of unit 4, sat_count must hold
    for (int i = 0; i < 8; i++) begin
      acc_mem[i] = 32'd0; bias_mem[i] = 8'd0; exp_d[i] = 128;
    end
    acc_mem[0] = 32'd32000;  exp_d[0] = 255;
    acc_mem[1] = -32'sd20480; exp_d[1] = 0;
    run(4, -1, cyc);
    chk_writes(4);
    chk("t4_sat_hold", 32'(sat_count), 32'd2);
    repeat (3) begin
      @(negedge clk);
      chk("t4_no_done", 32'(done), 32'd0);
    end
    chk("t4_no_late_wr", 32'(wa.size()), 32'd4);
    run(-1, -1, cyc);
    chk("t4_rerun_cycles", 32'(cyc), 32'd33);
    chk_writes(8);
    after_done();

    // 5a: async reset during WRITE
    wa.delete(); wd.delete();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(mem.ht_wr_valid && mem.ht_wr_addr == 3'd1) && cyc < 100);
    chk("t5_reach_write", 32'(cyc < 100), 32'd1);
    #1 resetn = 0;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_valid", 32'(mem.ht_wr_valid), 32'd0);
    chk("t5_waddr", 32'(mem.ht_wr_addr), 32'd0);
    chk("t5_wdata", 32'(mem.ht_wr_data), 32'd0);
    chk("t5_state", 32'(conv_state), 32'd0);
    chk("t5_sat", 32'(sat_count), 32'd0);
    nw = wa.size();
    repeat (4) @(negedge clk);
    resetn = 1;
    repeat (6) begin
      @(negedge clk);
      chk("t5_no_done", 32'(done), 32'd0);
    end
    chk("t5_no_wr", 32'(wa.size()), 32'(nw));

    // 5b: start while busy is ignored
    for (int i = 0; i < 8; i++) exp_d[i] = 138 + 10 * i;
    for (int i = 0; i < 8; i++) begin
      acc_mem[i] = 32'(1280 * i); bias_mem[i] = 8'd20;
    end
    run(-1, 10, cyc);
    chk("t5_restart_cycles", 32'(cyc), 32'd33);
    chk_writes(8);
    after_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
